rv_demux2_64: RTL and testbench

- Registered 1-to-2 demultiplexer for 64-bit datapath words, with valid/ready handshakes on all three sides.
- Steers each accepted input word to output A or output B according to a per-word select bit.
- Each output has an independent FIFO of DEPTH entries, so a stalled consumer does not block the other channel until its own FIFO fills.
- Sits between a single result producer and two consumers, for example a writeback path splitting ALU results between the register file and the LSU.

---
 rtl/rv_demux2_64.sv | 98 +++++++++
 tb/tb_rv_demux2_64.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_demux2_64.sv
// Registered 1-to-2 demultiplexer for 64-bit words with valid/ready on every side.
// Each output owns a DEPTH-entry FIFO so a stalled consumer only blocks its own channel.
module rv_demux2_64 #(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   inData,
    input  logic          inSel,
    input  logic          inValid,
    output logic          inReady,
    output logic [63:0]   outA,
    output logic          outAValid,
    input  logic          outAReady,
    output logic [63:0]   outB,
    output logic          outBValid,
    input  logic          outBReady,
    output logic [CW-1:0] cntA,
    output logic [CW-1:0] cntB
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   memA_q [DEPTH];
    logic [63:0]   memB_q [DEPTH];
    logic [PW-1:0] headA_q, headA_d, tailA_q, tailA_d;
    logic [PW-1:0] headB_q, headB_d, tailB_q, tailB_d;
    logic [CW-1:0] cntA_q, cntA_d, cntB_q, cntB_d;
    logic          pushA, pushB, popA, popB;

    // Input readiness looks only at registered counts, never at the output readies.
    assign inReady   = inSel ? (cntB_q != FULL) : (cntA_q != FULL);
    assign pushA     = inValid & inReady & ~inSel;
    assign pushB     = inValid & inReady & inSel;

    assign outAValid = (cntA_q != '0);
    assign outBValid = (cntB_q != '0);
    assign popA      = outAValid & outAReady;
    assign popB      = outBValid & outBReady;

    assign outA      = outAValid ? memA_q[headA_q] : 64'd0;
    assign outB      = outBValid ? memB_q[headB_q] : 64'd0;
    assign cntA      = cntA_q;
    assign cntB      = cntB_q;

    always_comb begin
        headA_d = headA_q;
        tailA_d = tailA_q;
        cntA_d  = cntA_q;
        headB_d = headB_q;
        tailB_d = tailB_q;
        cntB_d  = cntB_q;

        if (popA)  headA_d = headA_q + PW'(1);
        if (pushA) tailA_d = tailA_q + PW'(1);
        if (popB)  headB_d = headB_q + PW'(1);
        if (pushB) tailB_d = tailB_q + PW'(1);

        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({pushA, popA})
            2'b10:   cntA_d = cntA_q + CW'(1);
            2'b01:   cntA_d = cntA_q - CW'(1);
            default: cntA_d = cntA_q;
        endcase
        case ({pushB, popB})
            2'b10:   cntB_d = cntB_q + CW'(1);
            2'b01:   cntB_d = cntB_q - CW'(1);
            default: cntB_d = cntB_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headA_q <= '0;
            tailA_q <= '0;
            cntA_q  <= '0;
            headB_q <= '0;
            tailB_q <= '0;
            cntB_q  <= '0;
        end else begin
            headA_q <= headA_d;
            tailA_q <= tailA_d;
            cntA_q  <= cntA_d;
            headB_q <= headB_d;
            tailB_q <= tailB_d;
            cntB_q  <= cntB_d;
        end
    end

    // Storage carries no reset; validity is tracked purely by the counts.
    always_ff @(posedge clk) begin
        if (pushA) memA_q[tailA_q] <= inData;
        if (pushB) memB_q[tailB_q] <= inData;
    end

endmodule

// File: tb/tb_rv_demux2_64.sv
// Self-checking bench for rv_demux2_64: directed scenarios plus a randomized run
// compared against a queue-based model of the two output FIFOs.
module tb_rv_demux2_64;

    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   inData;
    logic          inSel;
    logic          inValid;
    logic          inReady;
    logic [63:0]   outA;
    logic          outAValid;
    logic          outAReady;
    logic [63:0]   outB;
    logic          outBValid;
    logic          outBReady;
    logic [CW-1:0] cntA;
    logic [CW-1:0] cntB;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] qA[$];
    logic [63:0] qB[$];

    rv_demux2_64 #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .inData(inData), .inSel(inSel), .inValid(inValid), .inReady(inReady),
        .outA(outA), .outAValid(outAValid), .outAReady(outAReady),
        .outB(outB), .outBValid(outBValid), .outBReady(outBReady),
        .cntA(cntA), .cntB(cntB)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and update the model from the handshakes the model itself predicts.
    task automatic tick();
        bit pushOk, popA, popB, sel;
        logic [63:0] d;
        sel    = inSel;
        d      = inData;
        pushOk = inValid && (sel ? (qB.size() < DEPTH) : (qA.size() < DEPTH));
        popA   = (qA.size() > 0) && outAReady;
        popB   = (qB.size() > 0) && outBReady;
        @(posedge clk);
        if (popA) void'(qA.pop_front());
        if (popB) void'(qB.pop_front());
        if (pushOk) begin
            if (sel) qB.push_back(d);
            else     qA.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idleInputs();
        inValid   = 1'b0;
        inSel     = 1'b0;
        inData    = 64'd0;
        outAReady = 1'b0;
        outBReady = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idleInputs();
        repeat (2) @(negedge clk);
        compared++; if (outAValid !== 1'b0 || outBValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got=%b%b exp=00", outAValid, outBValid); end
        compared++; if (cntA !== '0 || cntB !== '0) begin mismatched++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", cntA, cntB); end
        rst_n = 1'b1;
        @(negedge clk);

        inValid = 1'b1; inSel = 1'b0; inData = 64'h0A0;  tick();
        inData = 64'h0A1;                                 tick();
        inSel = 1'b1; inData = 64'h0B0;                   tick();
        inValid = 1'b0;
        compared++; if (cntA !== 2 || cntB !== 1) begin mismatched++; $display("[TB] FAIL prereset_cnt got=%0d/%0d exp=2/1", cntA, cntB); end

        #2 rst_n = 1'b0;
        #1;
        compared++; if (outAValid !== 1'b0 || outBValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_valid got=%b%b exp=00", outAValid, outBValid); end
        compared++; if (outA !== 64'd0 || outB !== 64'd0) begin mismatched++; $display("[TB] FAIL midreset_data got=%h/%h exp=0/0", outA, outB); end
        compared++; if (cntA !== '0 || cntB !== '0) begin mismatched++; $display("[TB] FAIL midreset_cnt got=%0d/%0d exp=0/0", cntA, cntB); end
        qA.delete();
        qB.delete();
        @(negedge clk);
        rst_n = 1'b1;
        inSel = 1'b0; #1;
        compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL postreset_ready_sel0 got=%b exp=1", inReady); end
        inSel = 1'b1; #1;
        compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL postreset_ready_sel1 got=%b exp=1", inReady); end
        inSel = 1'b0;
    endtask

    task automatic test_steering();
        outAReady = 1'b1; outBReady = 1'b1;
        inValid = 1'b1; inSel = 1'b0; inData = 64'h1111;
        tick();
        compared++; if (outAValid !== 1'b1 || outA !== 64'h1111) begin mismatched++; $display("[TB] FAIL steer_A got=%b/%h exp=1/1111", outAValid, outA); end
        compared++; if (outBValid !== 1'b0) begin mismatched++; $display("[TB] FAIL steer_B_idle got=%b exp=0", outBValid); end
        inSel = 1'b1; inData = 64'h2222;
        tick();
        compared++; if (outAValid !== 1'b0) begin mismatched++; $display("[TB] FAIL steer_A_once got=%b exp=0", outAValid); end
        compared++; if (outBValid !== 1'b1 || outB !== 64'h2222) begin mismatched++; $display("[TB] FAIL steer_B got=%b/%h exp=1/2222", outBValid, outB); end
        inValid = 1'b0;
        tick();
        compared++; if (outBValid !== 1'b0 || outB !== 64'd0) begin mismatched++; $display("[TB] FAIL steer_B_once got=%b/%h exp=0/0", outBValid, outB); end
    endtask

    task automatic test_fill_block();
        idleInputs();
        inValid = 1'b1; inSel = 1'b0; inData = 64'hA0; tick();
        inData = 64'hA1;                               tick();
        inData = 64'hA2; #1;
        compared++; if (cntA !== 2) begin mismatched++; $display("[TB] FAIL fill_cnt got=%0d exp=2", cntA); end
        compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_ready got=%b exp=0", inReady); end
        tick();
        compared++; if (cntA !== 2 || outA !== 64'hA0) begin mismatched++; $display("[TB] FAIL fill_hold got=%0d/%h exp=2/a0", cntA, outA); end
        outAReady = 1'b1; #1;
        compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL fill_nopass got=%b exp=0", inReady); end
        tick();
        compared++; if (outA !== 64'hA1 || cntA !== 1 || inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_pop0 got=%h/%0d/%b exp=a1/1/1", outA, cntA, inReady); end
        tick();
        compared++; if (outA !== 64'hA2 || cntA !== 1) begin mismatched++; $display("[TB] FAIL fill_pop1 got=%h/%0d exp=a2/1", outA, cntA); end
        inValid = 1'b0;
        tick();
        compared++; if (outAValid !== 1'b0 || cntA !== 0) begin mismatched++; $display("[TB] FAIL fill_drain got=%b/%0d exp=0/0", outAValid, cntA); end
    endtask

    task automatic test_head_of_line();
        idleInputs();
        inValid = 1'b1; inSel = 1'b0; inData = 64'hA5; tick();
        inData = 64'hA6;                               tick();
        inData = 64'hA7; #1;
        compared++; if (inReady !== 1'b0) begin mismatched++; $display("[TB] FAIL hol_block got=%b exp=0", inReady); end
        tick();
        inSel = 1'b1; inData = 64'hB5; #1;
        compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL hol_other got=%b exp=1", inReady); end
        tick();
        compared++; if (outBValid !== 1'b1 || outB !== 64'hB5) begin mismatched++; $display("[TB] FAIL hol_B got=%b/%h exp=1/b5", outBValid, outB); end
        compared++; if (cntA !== 2 || outA !== 64'hA5) begin mismatched++; $display("[TB] FAIL hol_A_kept got=%0d/%h exp=2/a5", cntA, outA); end
        inValid = 1'b0; outAReady = 1'b1; outBReady = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int maxCnt = 0;
        idleInputs();
        outBReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            inValid = 1'b1; inSel = 1'b1; inData = 64'(i); #1;
            compared++; if (inReady !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_ready[%0d] got=%b exp=1", i, inReady); end
            tick();
            compared++; if (outBValid !== 1'b1 || outB !== 64'(i)) begin mismatched++; $display("[TB] FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, outBValid, outB, 64'(i)); end
            if (int'(cntB) > maxCnt) maxCnt = int'(cntB);
        end
        compared++; if (maxCnt > 1) begin mismatched++; $display("[TB] FAIL b2b_maxcnt got=%0d exp<=1", maxCnt); end
        inValid = 1'b0;
        tick();
        compared++; if (cntB !== 0) begin mismatched++; $display("[TB] FAIL b2b_empty got=%0d exp=0", cntB); end
    endtask

    task automatic test_concurrent();
        idleInputs();
        inValid = 1'b1; inSel = 1'b0; inData = 64'hC0; tick();
        inSel = 1'b1; inData = 64'hD0;                 tick();
        compared++; if (cntA !== 1 || cntB !== 1) begin mismatched++; $display("[TB] FAIL conc_setup got=%0d/%0d exp=1/1", cntA, cntB); end
        inSel = 1'b0; inData = 64'hC1; outAReady = 1'b1; outBReady = 1'b1;
        tick();
        compared++; if (cntA !== 1 || cntB !== 0) begin mismatched++; $display("[TB] FAIL conc_cnt got=%0d/%0d exp=1/0", cntA, cntB); end
        compared++; if (outA !== 64'hC1 || outBValid !== 1'b0) begin mismatched++; $display("[TB] FAIL conc_data got=%h/%b exp=c1/0", outA, outBValid); end
        inValid = 1'b0;
        tick();
        compared++; if (cntA !== 0) begin mismatched++; $display("[TB] FAIL conc_drain got=%0d exp=0", cntA); end
    endtask

    task automatic test_random();
        logic [63:0] expA, expB;
        bit expReady;
        for (int i = 0; i < 400; i++) begin
            inValid   = ($urandom_range(0, 3) != 0);
            inSel     = 1'($urandom);
            inData    = {$urandom, $urandom};
            outAReady = ($urandom_range(0, 2) != 0);
            outBReady = ($urandom_range(0, 2) == 0);
            #1;
            expA     = (qA.size() > 0) ? qA[0] : 64'd0;
            expB     = (qB.size() > 0) ? qB[0] : 64'd0;
            expReady = inSel ? (qB.size() < DEPTH) : (qA.size() < DEPTH);
            compared++; if (inReady !== expReady) begin mismatched++; $display("[TB] FAIL rnd_ready[%0d] got=%b exp=%b", i, inReady, expReady); end
            compared++; if (outAValid !== (qA.size() > 0) || outA !== expA || cntA !== CW'(qA.size())) begin mismatched++; $display("[TB] FAIL rnd_A[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, outAValid, outA, cntA, qA.size() > 0, expA, qA.size()); end
            compared++; if (outBValid !== (qB.size() > 0) || outB !== expB || cntB !== CW'(qB.size())) begin mismatched++; $display("[TB] FAIL rnd_B[%0d] got=%b/%h/%0d exp=%b/%h/%0d", i, outBValid, outB, cntB, qB.size() > 0, expB, qB.size()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_steering();
        test_fill_block();
        test_head_of_line();
        test_back_to_back();
        test_concurrent();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
